// File: rtl/lcd_write_arbiter_if.sv
// Bundle of the two requester ports and the LCD controller handshake.
interface lcd_write_arbiter_if;
  logic       iREQ0;
  logic       iRS0;
  logic [7:0] iDATA0;
  logic       oACK0;
  logic       iREQ1;
  logic       iRS1;
  logic [7:0] iDATA1;
  logic       oACK1;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_Start;
  logic       iLCD_Done;
  logic       oBUSY;
  logic       oGRANT;

  // Arbiter side
  modport slave (
    input  iREQ0, iRS0, iDATA0, iREQ1, iRS1, iDATA1, iLCD_Done,
    output oACK0, oACK1, oLCD_DATA, oLCD_RS, oLCD_Start, oBUSY, oGRANT
  );

  // Requester / controller side
  modport master (
    output iREQ0, iRS0, iDATA0, iREQ1, iRS1, iDATA1, iLCD_Done,
    input  oACK0, oACK1, oLCD_DATA, oLCD_RS, oLCD_Start, oBUSY, oGRANT
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one HD44780-style LCD controller between two
// requesters; inserts the LCD execution delay before acknowledging.
module lcd_write_arbiter #(
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned DLY_SHORT = 262142,
  parameter int unsigned DLY_LONG  = 1000000
) (
  input  logic               iCLK,
  input  logic               iRST,
  lcd_write_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(DLY_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(DLY_LONG - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    DELAY     = 2'd2,
    ACK       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             start_q, start_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;

  logic             sel_c;
  logic             long_cmd_c;

  // Clear and Home commands need the long execution time.
  assign long_cmd_c = (rs_q == 1'b0) && (data_q[7:2] == 6'd0) && (data_q != 8'h00);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    start_d = start_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    sel_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.iREQ0 || bus.iREQ1) begin
          // On a tie the port not served last wins.
          if (bus.iREQ0 && bus.iREQ1) begin
            sel_c = ~last_q;
          end else begin
            sel_c = bus.iREQ1;
          end
          grant_d = sel_c;
          data_d  = sel_c ? bus.iDATA1 : bus.iDATA0;
          rs_d    = sel_c ? bus.iRS1 : bus.iRS0;
          start_d = 1'b1;
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (bus.iLCD_Done) begin
          start_d = 1'b0;
          cnt_d   = long_cmd_c ? LONG_LD : SHORT_LD;
          state_d = DELAY;
        end
      end

      DELAY: begin
        if (cnt_q == '0) begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ACK: begin
        last_d  = grant_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight byte.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      start_q <= start_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign bus.oLCD_DATA  = data_q;
  assign bus.oLCD_RS    = rs_q;
  assign bus.oLCD_Start = start_q;
  assign bus.oACK0      = ack0_q;
  assign bus.oACK1      = ack1_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oGRANT     = grant_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with a 3-cycle controller model.
module tb_lcd_write_arbiter;

  logic iCLK;
  logic iRST;
  logic mdl_done;
  logic spur_done;
  logic [1:0] scnt;
  int   cyc;
  int   checks;
  int   failures;

  lcd_write_arbiter_if bus();

  lcd_write_arbiter #(
    .CNT_W    (20),
    .DLY_SHORT(4),
    .DLY_LONG (16)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  assign bus.iLCD_Done = mdl_done | spur_done;

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // Controller model: one-cycle Done, sampled 3 edges after Start rises.
  always @(posedge iCLK) begin
    cyc <= cyc + 1;
    if (iRST) begin
      scnt     <= 2'd0;
      mdl_done <= 1'b0;
    end else if (bus.oLCD_Start && !mdl_done) begin
      if (scnt == 2'd1) begin
        mdl_done <= 1'b1;
        scnt     <= 2'd0;
      end else begin
        scnt <= scnt + 2'd1;
      end
    end else begin
      mdl_done <= 1'b0;
      scnt     <= 2'd0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit         port;
    bit         rs;
    logic [7:0] data;
    int         dly;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge iCLK);
  endtask

  task automatic set_req(input bit port, input bit v, input bit rs, input logic [7:0] d);
    if (port) begin
      bus.iREQ1 = v; bus.iRS1 = rs; bus.iDATA1 = d;
    end else begin
      bus.iREQ0 = v; bus.iRS0 = rs; bus.iDATA0 = d;
    end
  endtask

  function automatic bit ackp(input bit port);
    return port ? bus.oACK1 : bus.oACK0;
  endfunction

  task automatic do_reset();
    iRST = 1'b1;
    tick();
    tick();
    iRST = 1'b0;
    tick();
  endtask

  // Wait (bounded) until oLCD_Start is seen high at a negedge.
  task automatic wait_start(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.oLCD_Start) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  // From the first Start-high sample, count Start cycles and idle cycles to ACK.
  task automatic measure(input bit port, output int start_cyc, output int dly_cyc,
                         output bit other_seen, output bit ok);
    start_cyc  = 0;
    dly_cyc    = 0;
    other_seen = 1'b0;
    while (bus.oLCD_Start && start_cyc < 60) begin
      start_cyc++;
      tick();
    end
    while (!ackp(port) && dly_cyc < 60) begin
      if (ackp(~port)) other_seen = 1'b1;
      dly_cyc++;
      tick();
    end
    if (ackp(~port)) other_seen = 1'b1;
    ok = ackp(port);
  endtask

  initial begin
    int  n, sc, dc, t_prev;
    bit  ok, oth, seen_a, seen_b;
    int  grants[6];
    int  times[6];

    checks    = 0;
    failures  = 0;
    cyc       = 0;
    spur_done = 1'b0;
    iRST      = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);

    vecs[0] = '{port: 1'b0, rs: 1'b1, data: 8'h41, dly: 4};
    vecs[1] = '{port: 1'b0, rs: 1'b0, data: 8'h01, dly: 16};
    vecs[2] = '{port: 1'b0, rs: 1'b0, data: 8'h02, dly: 16};
    vecs[3] = '{port: 1'b1, rs: 1'b0, data: 8'h03, dly: 16};
    vecs[4] = '{port: 1'b1, rs: 1'b0, data: 8'h06, dly: 4};
    vecs[5] = '{port: 1'b1, rs: 1'b0, data: 8'h80, dly: 4};
    vecs[6] = '{port: 1'b0, rs: 1'b0, data: 8'h00, dly: 4};
    vecs[7] = '{port: 1'b1, rs: 1'b1, data: 8'h01, dly: 4};

    // Reset values
    #1;
    check("rst_data",  int'(bus.oLCD_DATA), 0);
    check("rst_rs",    int'(bus.oLCD_RS), 0);
    check("rst_start", int'(bus.oLCD_Start), 0);
    check("rst_ack0",  int'(bus.oACK0), 0);
    check("rst_ack1",  int'(bus.oACK1), 0);
    check("rst_busy",  int'(bus.oBUSY), 0);
    check("rst_grant", int'(bus.oGRANT), 0);
    tick();
    iRST = 1'b0;
    tick();

    // Single transfers and long/short delay decode
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].port, 1'b1, vecs[i].rs, vecs[i].data);
      tick();
      wait_start(n, ok);
      check($sformatf("v%0d_start_seen", i), int'(ok), 1);
      check($sformatf("v%0d_start_lat", i), n, 0);
      check($sformatf("v%0d_data", i), int'(bus.oLCD_DATA), int'(vecs[i].data));
      check($sformatf("v%0d_rs", i), int'(bus.oLCD_RS), int'(vecs[i].rs));
      check($sformatf("v%0d_grant", i), int'(bus.oGRANT), int'(vecs[i].port));
      check($sformatf("v%0d_busy", i), int'(bus.oBUSY), 1);
      measure(vecs[i].port, sc, dc, oth, ok);
      check($sformatf("v%0d_start_cycles", i), sc, 3);
      check($sformatf("v%0d_delay", i), dc, vecs[i].dly);
      check($sformatf("v%0d_ack", i), int'(ok), 1);
      check($sformatf("v%0d_other_ack", i), int'(oth), 0);
      set_req(vecs[i].port, 1'b0, vecs[i].rs, vecs[i].data);
      tick();
      check($sformatf("v%0d_idle_busy", i), int'(bus.oBUSY), 0);
      check($sformatf("v%0d_ack_pulse", i), int'(ackp(vecs[i].port)), 0);
    end

    // Tie after reset: port 0 first, port 1 one idle cycle after ACK0
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 8'h38);
    set_req(1'b1, 1'b1, 1'b1, 8'h30);
    tick();
    wait_start(n, ok);
    check("tie_first_grant", int'(bus.oGRANT), 0);
    check("tie_first_data", int'(bus.oLCD_DATA), 8'h38);
    measure(1'b0, sc, dc, oth, ok);
    check("tie_first_ack", int'(ok), 1);
    check("tie_first_delay", dc, 4);
    check("tie_first_ack1", int'(oth), 0);
    set_req(1'b0, 1'b0, 1'b0, 8'h38);
    tick();
    check("tie_gap_start", int'(bus.oLCD_Start), 0);
    check("tie_gap_busy", int'(bus.oBUSY), 0);
    tick();
    check("tie_second_start", int'(bus.oLCD_Start), 1);
    check("tie_second_grant", int'(bus.oGRANT), 1);
    check("tie_second_data", int'(bus.oLCD_DATA), 8'h30);
    check("tie_second_rs", int'(bus.oLCD_RS), 1);
    measure(1'b1, sc, dc, oth, ok);
    check("tie_second_ack", int'(ok), 1);
    set_req(1'b1, 1'b0, 1'b1, 8'h30);
    tick();

    // Fairness with both requests held high
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 8'h38);
    set_req(1'b1, 1'b1, 1'b1, 8'h30);
    tick();
    for (int i = 0; i < 6; i++) begin
      wait_start(n, ok);
      check($sformatf("fair%0d_seen", i), int'(ok), 1);
      grants[i] = int'(bus.oGRANT);
      times[i]  = cyc;
      measure(bus.oGRANT, sc, dc, oth, ok);
      check($sformatf("fair%0d_ack", i), int'(ok), 1);
      if (i == 5) begin
        set_req(1'b0, 1'b0, 1'b0, 8'h38);
        set_req(1'b1, 1'b0, 1'b1, 8'h30);
      end
      tick();
    end
    t_prev = times[0];
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fair%0d_grant", i), grants[i], i % 2);
      if (i > 0) begin
        check($sformatf("fair%0d_spacing", i), times[i] - t_prev, 9);
        t_prev = times[i];
      end
    end
    tick();
    check("fair_end_busy", int'(bus.oBUSY), 0);

    // Reset during DELAY abandons the transfer
    do_reset();
    set_req(1'b0, 1'b1, 1'b1, 8'h41);
    tick();
    wait_start(n, ok);
    for (int i = 0; i < 10 && bus.oLCD_Start; i++) tick();
    tick();
    check("mid_in_delay_busy", int'(bus.oBUSY), 1);
    iRST = 1'b1;
    #1;
    check("mid_rst_start", int'(bus.oLCD_Start), 0);
    check("mid_rst_busy", int'(bus.oBUSY), 0);
    check("mid_rst_ack0", int'(bus.oACK0), 0);
    check("mid_rst_ack1", int'(bus.oACK1), 0);
    check("mid_rst_data", int'(bus.oLCD_DATA), 0);
    set_req(1'b0, 1'b0, 1'b1, 8'h41);
    tick();
    iRST = 1'b0;
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.oACK0 || bus.oACK1) seen_a = 1'b1;
      if (bus.oBUSY) seen_b = 1'b1;
    end
    check("mid_no_ack", int'(seen_a), 0);
    check("mid_no_busy", int'(seen_b), 0);
    set_req(1'b0, 1'b1, 1'b0, 8'h06);
    set_req(1'b1, 1'b1, 1'b0, 8'h80);
    tick();
    wait_start(n, ok);
    check("mid_tie_grant", int'(bus.oGRANT), 0);
    measure(1'b0, sc, dc, oth, ok);
    check("mid_tie_ack", int'(ok), 1);
    set_req(1'b0, 1'b0, 1'b0, 8'h06);
    set_req(1'b1, 1'b0, 1'b0, 8'h80);
    tick();
    tick();
    check("mid_end_busy", int'(bus.oBUSY), 0);

    // Spurious Done in IDLE and DELAY; late request from port 1
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    check("spur_idle_busy", int'(bus.oBUSY), 0);
    check("spur_idle_start", int'(bus.oLCD_Start), 0);
    set_req(1'b0, 1'b1, 1'b0, 8'h06);
    tick();
    wait_start(n, ok);
    check("spur_p0_grant", int'(bus.oGRANT), 0);
    for (int i = 0; i < 10 && bus.oLCD_Start; i++) tick();
    dc = 1;
    spur_done = 1'b1;
    set_req(1'b1, 1'b1, 1'b1, 8'h55);
    tick();
    spur_done = 1'b0;
    seen_a = 1'b0;
    while (!bus.oACK0 && dc < 40) begin
      if (bus.oLCD_Start) seen_a = 1'b1;
      dc++;
      tick();
    end
    check("spur_delay_len", dc, 4);
    check("spur_no_restart", int'(seen_a), 0);
    check("spur_ack0", int'(bus.oACK0), 1);
    check("spur_ack1_low", int'(bus.oACK1), 0);
    set_req(1'b0, 1'b0, 1'b0, 8'h06);
    tick();
    check("late_gap_start", int'(bus.oLCD_Start), 0);
    tick();
    check("late_start", int'(bus.oLCD_Start), 1);
    check("late_grant", int'(bus.oGRANT), 1);
    check("late_data", int'(bus.oLCD_DATA), 8'h55);
    measure(1'b1, sc, dc, oth, ok);
    check("late_ack1", int'(ok), 1);
    check("late_delay", dc, 4);
    set_req(1'b1, 1'b0, 1'b1, 8'h55);
    tick();
    check("late_end_busy", int'(bus.oBUSY), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single HD44780-style LCD_Controller between two independent requesters, such as the boot/static-text sequencer and a live DDS frequency/phase readout. It accepts one {RS, DATA} byte per request, hands it to the controller, and waits for the controller's done pulse. It then holds the bus idle for the LCD's command execution time before acknowledging the requester. Simultaneous requests are resolved round-robin, so neither source can starve the other.

## Interface
Parameters:
- CNT_W, 20, width of the post-transfer delay counter.
- DLY_SHORT, 262142, idle cycles after a normal command or data write. Must be >= 1.
- DLY_LONG, 1000000, idle cycles after a Clear (0x01) or Home (0x02/0x03) command with RS=0. Must be >= 1 and fit in CNT_W.

Ports:
- iCLK  in  1  system clock. All logic is on the rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iREQ0  in  1  port 0 request (level). Held with iRS0/iDATA0 stable until oACK0.
- iRS0  in  1  port 0 register select (0 = command, 1 = data).
- iDATA0  in  8  port 0 byte.
- oACK0  out  1  port 0 acknowledge, one-cycle pulse.
- iREQ1, iRS1, iDATA1, oACK1: same as port 0, for port 1.
- oLCD_DATA  out  8  to controller iDATA.
- oLCD_RS  out  1  to controller iRS.
- oLCD_Start  out  1  to controller iStart. Level, held until iLCD_Done.
- iLCD_Done  in  1  from controller oDone.
- oBUSY  out  1  high whenever the state is not IDLE.
- oGRANT  out  1  index of the port currently or most recently served.

## Operation
- States: IDLE, WAIT_DONE, DELAY, ACK. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port that is not `last`. The `last` register resets to 1, so port 0 wins the first tie.
  - On grant: latch that port's RS/DATA into oLCD_RS/oLCD_DATA, set oGRANT, set oLCD_Start=1, go to WAIT_DONE.
- WAIT_DONE: hold oLCD_Start=1 and hold the latched data. When iLCD_Done=1:
  - Clear oLCD_Start.
  - Load the counter with DLY_LONG-1 if oLCD_RS=0 and oLCD_DATA[7:2]==0 and oLCD_DATA!=0; otherwise load DLY_SHORT-1.
  - Go to DELAY.
- DELAY: decrement the counter. At 0, go to ACK. DELAY therefore lasts exactly DLY cycles.
- ACK: the oACKn flop of the granted port is high for this single cycle. Set `last` to the granted port. Go to IDLE.
- Requester rule: on the edge where it samples oACKn=1, the requester deasserts iREQn or presents the next byte. A request still high in the following IDLE cycle is served as a new transfer.
- iLCD_Done outside WAIT_DONE is ignored.
- Requests arriving in any state other than IDLE are not sampled. They wait in IDLE.
- If a request drops before its ACK (protocol violation), the latched transfer still completes and is acknowledged.
- iRST asserted at any time, including mid-transfer:
  - All state returns to reset values immediately: IDLE, oLCD_Start=0, oACK0/1=0, counter=0, `last`=1.
  - The in-flight byte is abandoned with no ACK. Requesters must re-request.

## Timing
Reset values:
- oLCD_DATA=0x00, oLCD_RS=0, oLCD_Start=0
- oACK0=0, oACK1=0
- oBUSY=0, oGRANT=0

Cycle timing, with the grant edge as edge 0 (IDLE sees iREQ):
- Edge 0: oLCD_Start, oLCD_DATA/RS, oGRANT and oBUSY are valid after this edge.
- Tdone: the edge where iLCD_Done is sampled high. oLCD_Start is low after it.
- Tdone+DLY: ACK state entered. oACKn is high for cycle Tdone+DLY to Tdone+DLY+1.
- Tdone+DLY+1: IDLE, oBUSY=0. The earliest next grant is at edge Tdone+DLY+2.

Throughput is one byte per (Tctrl + DLY + 2) cycles, where Tctrl is the controller's Start-to-Done latency. This is the same for back-to-back requests from either port.

## Test plan
Bench settings: DLY_SHORT=4, DLY_LONG=16. The controller model pulses Done for one cycle, 3 cycles after Start rises.
1. Single data write: port 0 requests RS=1, 0x41 -> oLCD_DATA=0x41, oLCD_RS=1, oLCD_Start held 3 cycles. oACK0 pulses 4 cycles after Done, oACK1 stays 0.
2. Tie after reset: both ports request (port 0 0x38/RS0, port 1 0x30/RS1) -> port 0 is served first. Port 1 is granted 1 cycle after oACK0, oGRANT goes 0 then 1.
3. Fairness: both requests held high for 6 transfers -> grants alternate 0,1,0,1,0,1 with equal spacing.
4. Long-delay decode, with RS=0 throughout:
   - 0x01 and 0x02 -> 16 DELAY cycles.
   - 0x06 and 0x80 -> 4 DELAY cycles.
   - 0x00 -> 4 DELAY cycles.
5. Reset mid-operation: assert iRST during DELAY -> oLCD_Start=0, oBUSY=0 and oACK0/1=0 immediately, no ACK is issued. After release, port 0 wins a tie.
6. Spurious Done and late request: pulse iLCD_Done while in IDLE and while in DELAY -> no state change. Raise iREQ1 during port 0's DELAY -> port 1 is granted only after port 0's ACK.
